// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (LSB first); optional even parity via `RX_PARITY_EN
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_rate,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int NW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t                 state_q, state_d;
    logic [3:0]             s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d, d_out_q, d_out_d;
    logic                   rx_done_q, rx_done_d, frame_err_q, frame_err_d;
    logic                   rx_meta_q, rx_s_q;
`ifdef RX_PARITY_EN
    logic                   par_q, par_d, parity_err_q, parity_err_d;
`endif

    // two-flop synchronizer for the asynchronous serial line, idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // state, counters, shift register and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            sr_q        <= '0;
            d_out_q     <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            sr_q        <= sr_d;
            d_out_q     <= d_out_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // next-state logic: sample mid start bit, then every 16 ticks, stop at SB_TICKS
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        sr_d        = sr_q;
        d_out_d     = d_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: if (!rx_s_q) begin
                state_d = START;
                s_d     = '0;
            end
            START: if (baud_rate) begin
                if (s_q == 4'd7) begin
                    s_d     = '0;
                    n_d     = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else s_d = s_q + 4'd1;
            end
            DATA: if (baud_rate) begin
                if (s_q == 4'd15) begin
                    s_d  = '0;
                    sr_d = DATA_BITS'({rx_s_q, sr_q} >> 1);
`ifdef RX_PARITY_EN
                    if (n_q == NW'(DATA_BITS - 1)) state_d = PARITY;
`else
                    if (n_q == NW'(DATA_BITS - 1)) state_d = STOP;
`endif
                    else n_d = n_q + 1'b1;
                end else s_d = s_q + 4'd1;
            end
`ifdef RX_PARITY_EN
            PARITY: if (baud_rate) begin
                if (s_q == 4'd15) begin
                    s_d     = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end else s_d = s_q + 4'd1;
            end
`endif
            STOP: if (baud_rate) begin
                if (s_q == 4'(SB_TICKS - 1)) begin
                    s_d         = '0;
                    d_out_d     = sr_q;
                    frame_err_d = ~rx_s_q;
                    rx_done_d   = 1'b1;
                    state_d     = IDLE;
`ifdef RX_PARITY_EN
                    parity_err_d = ^{sr_q, par_q};
`endif
                end else s_d = s_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign d_out     = d_out_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with randomized frames (honours RX_PARITY_EN)
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] tick_cnt = 2'd0;
    logic       baud_rate;
    logic [7:0] d_out;
    logic       rx_done, frame_err, parity_err;

    typedef struct {
        logic [7:0] b;
        logic       fe;
        logic       pe;
    } exp_t;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] held = 8'h00;
    logic       prev_done = 1'b0;
    logic [7:0] last_byte = 8'h00;

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_rate(baud_rate), .rx(rx),
        .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // one baud tick every 4 clocks, so one bit is 64 clocks
    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign baud_rate = (tick_cnt == 2'd3);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops the scoreboard on every rx_done and checks output shape
    always @(negedge clk) begin
        if (!rst_n) begin
            held      = 8'h00;
            prev_done = 1'b0;
        end else begin
            if (rx_done) begin
                chk("rx_done_single_cycle", int'(prev_done), 0);
                if (sb.size() == 0) chk("unexpected_rx_done", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("d_out", int'(d_out), int'(e.b));
                    chk("frame_err", int'(frame_err), int'(e.fe));
                    chk("parity_err", int'(parity_err), int'(e.pe));
                end
                held = d_out;
            end else chk("d_out_stable", int'(d_out), int'(held));
            prev_done = rx_done;
        end
    end

    task automatic hold(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // bit-level framing from the line protocol; expectation pushed up front
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pflip);
        exp_t e;
        e.b  = b;
        e.fe = !stop_ok;
`ifdef RX_PARITY_EN
        e.pe = pflip;
`else
        e.pe = 1'b0;
`endif
        sb.push_back(e);
        last_byte = b;
        hold(1'b0, 64);
        for (int i = 0; i < 8; i++) hold(b[i], 64);
`ifdef RX_PARITY_EN
        hold((^b) ^ pflip, 64);
`endif
        if (stop_ok) hold(1'b1, 64);
        else begin
            hold(1'b0, 40);
            hold(1'b1, 24);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_rx_done", int'(rx_done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        rst_n = 1'b1;
        hold(1'b1, 20);
        send_frame(8'h99, 1, 0);
        hold(1'b1, 30);
        send_frame(8'h99, 1, 0);
        send_frame(8'hDA, 1, 0);
        hold(1'b1, 30);
        hold(1'b0, 16);
        hold(1'b1, 150);
        chk("glitch_d_out", int'(d_out), int'(last_byte));
        chk("glitch_no_pending", sb.size(), 0);
        send_frame(8'h55, 0, 0);
        hold(1'b1, 100);
        chk("ferr_held", int'(frame_err), 1);
        send_frame(8'h0F, 1, 0);
        hold(1'b1, 30);
        chk("ferr_cleared", int'(frame_err), 0);
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b0, 64);
        hold(1'b1, 64);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_d_out", int'(d_out), 0);
        chk("midrst_rx_done", int'(rx_done), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_parity_err", int'(parity_err), 0);
        @(negedge clk);
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 10);
        send_frame(8'hA5, 1, 0);
        hold(1'b1, 30);
`ifdef RX_PARITY_EN
        send_frame(8'h99, 1, 1);
        hold(1'b1, 30);
        chk("parity_err_set", int'(parity_err), 1);
        send_frame(8'h99, 1, 0);
        hold(1'b1, 30);
        chk("parity_err_clear", int'(parity_err), 0);
`endif
        for (int k = 0; k < 20; k++) begin
            logic [7:0] b;
            bit ok, pf;
            b  = 8'($urandom);
            ok = ($urandom_range(5) != 0);
            pf = 1'($urandom_range(1));
            send_frame(b, ok, pf);
            hold(1'b1, ok ? int'($urandom_range(0, 80)) : 70 + int'($urandom_range(0, 40)));
        end
        hold(1'b1, 800);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath, the downstream consumer of the `TX` serial line. It oversamples `rx` with the 16× tick from `BaudRateGenerator` and recovers 8N1 frames (LSB first). Each received byte is presented on `d_out` with a one-cycle `rx_done` strobe, along with framing and parity error flags.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame.
- `SB_TICKS`, 16: baud ticks spent in the stop bit before its sample.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `baud_rate`, input, 1: one-`clk`-wide tick at 16× the bit rate, from `BaudRateGenerator.out`.
- `rx`, input, 1: serial line; idles high; asynchronous to `clk`.
- `d_out`, output, `DATA_BITS`: last received byte.
- `rx_done`, output, 1: one-cycle pulse when `d_out` updates.
- `frame_err`, output, 1: stop bit sampled low for the current `d_out`.
- `parity_err`, output, 1: parity mismatch for the current `d_out`. Constant 0 unless `RX_PARITY_EN` is defined.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer, reset to 1. All decisions use the synchronized value `rx_s`.
- **FSM states:** IDLE, START, DATA, PARITY (only when `RX_PARITY_EN`), STOP.
- **Tick counter and bit counter:** a 4-bit tick counter `s` advances only on `baud_rate`. A bit counter `n` runs 0..`DATA_BITS`-1.
- **IDLE:** when `rx_s`=0, go to START with `s`=0. No `baud_rate` is needed to leave IDLE.
- **START:** on the tick where `s`=7 (mid start bit):
  - if `rx_s`=0, go to DATA with `s`=0, `n`=0;
  - if `rx_s`=1, treat it as a glitch and return to IDLE with no flags changed.
- **DATA:** on the tick where `s`=15, shift `rx_s` into the MSB of the shift register (right shift, so LSB arrives first) and set `s`=0.
  - After the sample with `n`=`DATA_BITS`-1, go to PARITY or STOP.
  - Otherwise `n`++.
- **PARITY:** on `s`=15, capture the parity bit and go to STOP with `s`=0.
- **STOP:** on the tick where `s`=`SB_TICKS`-1 (mid stop bit), in that same update:
  - `d_out` ← shift register;
  - `frame_err` ← ~`rx_s`;
  - `parity_err` updates;
  - `rx_done` ← 1;
  - go to IDLE.
- **Error frames:** a byte is delivered even when `frame_err`=1.
- **Re-arming:** returning to IDLE at mid stop bit allows back-to-back frames. A line held low after a framing error re-enters START immediately.
- **Flag persistence:** `frame_err` and `parity_err` hold until the next `rx_done`.

## Timing
- **Reset values:** `d_out`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0, FSM=IDLE, counters=0, synchronizer=1. Reset is asynchronous and may occur mid-frame; the partial frame is discarded.
- **Entry latency:** IDLE→START occurs 2–3 `clk` after the falling edge on `rx` (synchronizer plus one registered state update).
- **Frame latency:** `rx_done` rises in the `clk` cycle after the baud tick on which the stop bit is sampled. Without parity that is 8 + 16·`DATA_BITS` + `SB_TICKS` = 152 ticks after START entry; with parity, 168.
- **`rx_done` shape:**
  - high for exactly one `clk`;
  - never asserted in consecutive cycles;
  - cleared on the next `clk` regardless of `baud_rate`.
- **`d_out` stability:** `d_out` is stable from `rx_done` until the next `rx_done`.
- **No back-pressure:** an unread byte is overwritten by the next frame.
- **Ticks outside a frame:** `baud_rate` ticks arriving in IDLE are ignored.

## Configuration
- **`RX_PARITY_EN` defined:** one even-parity bit follows the data bits. `parity_err` = XOR of all data bits and the received parity bit, latched at STOP.
- **`RX_PARITY_EN` undefined:**
  - PARITY state and its logic are not compiled;
  - `parity_err` is tied to 0;
  - frames are 8N1.

## Test plan
- **Single frame:** after reset release, drive `rx` with a 0x99 frame at 16 ticks/bit → one `rx_done` pulse, `d_out`=0x99, `frame_err`=0.
- **Back-to-back frames:** 0x99 then 0xDA, the second start bit immediately following the first stop bit → two single-cycle pulses; `d_out`=0x99 then 0xDA; no errors.
- **Glitch rejection:** `rx` low for 4 ticks, then high → FSM returns to IDLE; no `rx_done`; `d_out` unchanged.
- **Framing error:** 0x55 with the stop bit driven 0, then the line held high → `rx_done` pulses, `d_out`=0x55, `frame_err`=1. The next clean 0x0F frame gives `frame_err`=0.
- **Reset mid-frame:** assert `rst_n`=0 after 3 data bits → all outputs 0 immediately and no `rx_done`. A following 0xA5 frame is received correctly.
- **Parity error (`RX_PARITY_EN` defined):** 0x99 with parity bit 1 → `parity_err`=1. The same byte with parity bit 0 → `parity_err`=0.
